// File: rtl/lane_arb_pkg.sv
// Shared types for the lane write arbiter: lane width, lane vector type and
// the round-robin priority encoding.
package lane_arb_pkg;

  localparam int LANE_W = 8;

  // Lane 0 is the MSB of the register.
  typedef logic [0:LANE_W-1] lane_t;

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  function automatic pri_e other_pri(input pri_e p);
    return (p == PRI_A) ? PRI_B : PRI_A;
  endfunction

endpackage

// File: rtl/lane_write_arbiter_if.sv
// Requester-side bundle of the lane write arbiter: both request/mask/data
// channels and their grants. The arbiter takes the slave view.
interface lane_write_arbiter_if
  import lane_arb_pkg::*;
#(
  parameter int W = LANE_W
);

  logic         req_a;
  logic [0:W-1] mask_a;
  logic [0:W-1] data_a;
  logic         gnt_a;

  logic         req_b;
  logic [0:W-1] mask_b;
  logic [0:W-1] data_b;
  logic         gnt_b;

  modport master (
    output req_a, mask_a, data_a,
    output req_b, mask_b, data_b,
    input  gnt_a, gnt_b
  );

  modport slave (
    input  req_a, mask_a, data_a,
    input  req_b, mask_b, data_b,
    output gnt_a, gnt_b
  );

endinterface

// File: rtl/lane_rr_pointer.sv
// Round-robin priority pointer: holds which requester wins the next conflict
// and hands priority to the other side after every conflict cycle.
module lane_rr_pointer
  import lane_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic conflict,
  output pri_e pri
);

  pri_e pri_q;
  pri_e pri_d;

  always_comb begin
    pri_d = pri_q;
    if (conflict) begin
      pri_d = other_pri(pri_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_A;
    end else begin
      pri_q <= pri_d;
    end
  end

  assign pri = pri_q;

endmodule

// File: rtl/lane_write_arbiter.sv
// Single-owner write controller for a lane-addressed register shared by two
// requesters. Optional feature macro: COLLISION_COUNT_EN (conflict counter).
module lane_write_arbiter
  import lane_arb_pkg::*;
#(
  parameter int W     = LANE_W,
  parameter int CNT_W = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  lane_write_arbiter_if.slave bus,
  output logic [0:W-1]       aa,
  output logic               coll,
  output logic [CNT_W-1:0]   coll_cnt
);

  pri_e         pri;
  logic         conflict;
  logic         gnt_a;
  logic         gnt_b;
  logic [0:W-1] aa_q;
  logic [0:W-1] aa_d;
  logic         coll_q;
  logic         coll_d;

  assign conflict = bus.req_a & bus.req_b & (|(bus.mask_a & bus.mask_b));

  lane_rr_pointer u_rr_pointer (
    .clk      (clk),
    .rst_n    (rst_n),
    .conflict (conflict),
    .pri      (pri)
  );

  // Without a conflict every request is granted; on a conflict only the
  // priority holder is, so granted masks never overlap.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      gnt_a = bus.req_a & (~conflict | (pri == PRI_A));
      gnt_b = bus.req_b & (~conflict | (pri == PRI_B));
    end
  end

  assign bus.gnt_a = gnt_a;
  assign bus.gnt_b = gnt_b;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_lane
      assign aa_d[gi] = (gnt_a & bus.mask_a[gi]) ? bus.data_a[gi] :
                        (gnt_b & bus.mask_b[gi]) ? bus.data_b[gi] :
                                                   aa_q[gi];
    end
  endgenerate

  assign coll_d = conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aa_q   <= '0;
      coll_q <= 1'b0;
    end else begin
      aa_q   <= aa_d;
      coll_q <= coll_d;
    end
  end

  assign aa   = aa_q;
  assign coll = coll_q;

`ifdef COLLISION_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign coll_cnt = cnt_q;
`else
  assign coll_cnt = '0;
`endif

endmodule

// File: tb/tb_lane_write_arbiter.sv
// Directed scoreboard bench for lane_write_arbiter: the driver queues the
// expected response per cycle, a negedge monitor pops and compares it.
module tb_lane_write_arbiter;

  logic       clk;
  logic       rst_n;
  logic [0:7] aa;
  logic       coll;
  logic [1:0] coll_cnt;

  lane_write_arbiter_if #(.W(8)) bus ();

  lane_write_arbiter #(
    .W     (8),
    .CNT_W (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .aa       (aa),
    .coll     (coll),
    .coll_cnt (coll_cnt)
  );

  typedef struct {
    int         id;
    logic       gnt_a;
    logic       gnt_b;
    logic [7:0] aa;
    logic       coll;
    logic [1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   step_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL step %0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      $display("step %0d gnt_a=%b gnt_b=%b aa=%h coll=%b cnt=%0d", e.id,
               bus.gnt_a, bus.gnt_b, aa, coll, coll_cnt);
      check("gnt_a", e.id, {31'd0, bus.gnt_a}, {31'd0, e.gnt_a});
      check("gnt_b", e.id, {31'd0, bus.gnt_b}, {31'd0, e.gnt_b});
      check("aa",    e.id, {24'd0, aa},        {24'd0, e.aa});
      check("coll",  e.id, {31'd0, coll},      {31'd0, e.coll});
      check("cnt",   e.id, {30'd0, coll_cnt},  {30'd0, e.cnt});
    end
  end

  // One cycle of stimulus; expected aa/coll/cnt are the values visible in
  // this cycle (result of the previous edge), gnt is for these inputs.
  task automatic step(input logic rst, input logic ra, input logic [7:0] ma, input logic [7:0] da,
                      input logic rb, input logic [7:0] mb, input logic [7:0] db,
                      input logic ega, input logic egb, input logic [7:0] eaa,
                      input logic ecoll, input logic [1:0] ecnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rst;
    bus.req_a  = ra;
    bus.mask_a = ma;
    bus.data_a = da;
    bus.req_b  = rb;
    bus.mask_b = mb;
    bus.data_b = db;
    e.id    = step_id;
    e.gnt_a = ega;
    e.gnt_b = egb;
    e.aa    = eaa;
    e.coll  = ecoll;
`ifdef COLLISION_COUNT_EN
    e.cnt   = ecnt;
`else
    e.cnt   = 2'd0;
`endif
    sbq.push_back(e);
    step_id++;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.req_a  = 1'b0;
    bus.mask_a = '0;
    bus.data_a = '0;
    bus.req_b  = 1'b0;
    bus.mask_b = '0;
    bus.data_b = '0;

    //    rst ra ma     da     rb mb     db     ga gb aa     coll cnt
    // reset with both requesting: grants forced low
    step(0, 1, 8'hFF, 8'hFF, 1, 8'hFF, 8'hFF, 0, 0, 8'h00, 0, 2'd0);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0);
    // disjoint masks, both granted
    step(1, 1, 8'hF0, 8'hAA, 1, 8'h0F, 8'h55, 1, 1, 8'h00, 0, 2'd0);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'hA5, 0, 2'd0);
    // clear register to 00
    step(1, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'hA5, 0, 2'd0);
    // overlap: A wins, B held and granted next cycle
    step(1, 1, 8'hF8, 8'hFF, 1, 8'h1F, 8'h00, 1, 0, 8'h00, 0, 2'd0);
    step(1, 0, 8'h00, 8'h00, 1, 8'h1F, 8'h00, 0, 1, 8'hF8, 1, 2'd1);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'hE0, 0, 2'd1);
    // pri is now B: B wins the next conflict
    step(1, 1, 8'h80, 8'h00, 1, 8'h80, 8'h80, 0, 1, 8'hE0, 0, 2'd1);
    step(1, 1, 8'h80, 8'h00, 0, 8'h00, 8'h00, 1, 0, 8'hE0, 1, 2'd2);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h60, 0, 2'd2);
    // mid-operation reset: written F8 and coll pulse wiped asynchronously
    step(1, 1, 8'hF8, 8'hFF, 1, 8'h1F, 8'h00, 1, 0, 8'h60, 0, 2'd2);
    step(0, 0, 8'h00, 8'h00, 1, 8'h1F, 8'h00, 0, 0, 8'h00, 0, 2'd0);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd0);
    // fairness after reset (pri back to A) plus counter saturation
    step(1, 1, 8'hFF, 8'hC3, 1, 8'hFF, 8'h3C, 1, 0, 8'h00, 0, 2'd0);
    step(1, 1, 8'hFF, 8'hC3, 1, 8'hFF, 8'h3C, 0, 1, 8'hC3, 1, 2'd1);
    step(1, 1, 8'hFF, 8'hC3, 1, 8'hFF, 8'h3C, 1, 0, 8'h3C, 1, 2'd2);
    step(1, 1, 8'hFF, 8'hC3, 1, 8'hFF, 8'h3C, 0, 1, 8'hC3, 1, 2'd3);
    step(1, 1, 8'hFF, 8'hC3, 1, 8'hFF, 8'h3C, 1, 0, 8'h3C, 1, 2'd3);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'hC3, 1, 2'd3);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'hC3, 0, 2'd3);
    // empty mask: granted, never a conflict, writes nothing
    step(1, 1, 8'h00, 8'hFF, 1, 8'hFF, 8'h00, 1, 1, 8'hC3, 0, 2'd3);
    step(1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 2'd3);

    repeat (3) @(posedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
